// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_pkg
//   Shared definitions for the SRAM port arbiter slice: FSM state encodings
//   and the port identifiers used by the winner-select logic and the
//   last-grant register.
// -----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
//   Combinational winner select for the SRAM port arbiter.
//   Build option ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to
//   the port that was not granted last; otherwise D has fixed priority unless
//   the starvation flag forces I.
// Ports
//   i_req_i       I-side request
//   d_req_i       D-side request (read or write)
//   last_grant_i  port granted on the previous transaction
//   starve_i      I has waited the maximum number of D grants
//   grant_vld_o   some port is requesting
//   grant_port_o  winning port (PORT_I / PORT_D), meaningful with grant_vld_o
// -----------------------------------------------------------------------------
module sram_arb_pick
  import sram_port_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  input  logic starve_i,
  output logic grant_vld_o,
  output logic grant_port_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_starve;
  assign unused_starve = starve_i;
`else
  logic unused_last;
  assign unused_last = last_grant_i;
`endif

  always_comb begin
    grant_vld_o  = i_req_i | d_req_i;
    grant_port_o = PORT_D;
    if (i_req_i && !d_req_i) begin
      grant_port_o = PORT_I;
    end else if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_port_o = (last_grant_i == PORT_D) ? PORT_I : PORT_D;
`else
      grant_port_o = starve_i ? PORT_I : PORT_D;
`endif
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one SRAM controller between the instruction-fetch refill port (I,
//   read-only) and the data-cache port (D, read/write). One SRAM transaction
//   is in flight at a time: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE.
//   All outputs are registered.
//   Build option ARB_ROUND_ROBIN_EN: alternate simultaneous requests instead
//   of fixed D priority with an I starvation guard.
// Ports
//   clock, rst                    clock, asynchronous active-high reset
//   i_rd_en, i_addr               I-side read request (level)
//   i_ready, i_rdata              I completion pulse and captured line
//   d_rd_en, d_wr_en, d_addr,
//   d_wdata                       D-side request (level), write wins if both
//   d_ready, d_rdata              D completion pulse and captured read line
//   sram_rd_en, sram_wr_en,
//   sram_addr, sram_wdata         request to SRAM controller
//   sram_ready, sram_rdata        SRAM controller completion and read line
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_ready,
  input  logic [LINE_W-1:0] sram_rdata
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  // Saturating increment: the counter parks at the limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_LIM) ? v : v + CNT_W'(1);
  endfunction

  arb_state_e        state_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;
  logic              sram_rd_en_q;
  logic              sram_wr_en_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic d_req;
  logic d_rd_only;
  logic starve_flag;
  logic grant_vld;
  logic grant_port;

  // A D request with both enables high is a write.
  assign d_req       = d_rd_en | d_wr_en;
  assign d_rd_only   = d_rd_en & ~d_wr_en;
  assign starve_flag = (starve_q == STARVE_LIM);

  sram_arb_pick u_pick (
    .i_req_i      (i_rd_en),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .starve_i     (starve_flag),
    .grant_vld_o  (grant_vld),
    .grant_port_o (grant_port)
  );

  // Starvation counter only moves on IDLE decisions, since requests are
  // ignored in every other state.
  always_comb begin
    starve_d = starve_q;
`ifdef ARB_ROUND_ROBIN_EN
    starve_d = '0;
`else
    if (state_q == ST_IDLE) begin
      if (!i_rd_en) begin
        starve_d = '0;
      end else if (grant_vld && grant_port == PORT_I) begin
        starve_d = '0;
      end else if (grant_vld && grant_port == PORT_D) begin
        starve_d = sat_inc(starve_q);
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      starve_q     <= '0;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            last_grant_q <= grant_port;
            if (grant_port == PORT_I) begin
              sram_rd_en_q <= 1'b1;
              sram_wr_en_q <= 1'b0;
              sram_addr_q  <= i_addr;
              sram_wdata_q <= '0;
              state_q      <= ST_GRANT_I;
            end else begin
              sram_rd_en_q <= d_rd_only;
              sram_wr_en_q <= d_wr_en;
              sram_addr_q  <= d_addr;
              sram_wdata_q <= d_wdata;
              state_q      <= ST_GRANT_D;
            end
          end
        end
        ST_GRANT_I: begin
          if (sram_ready) begin
            i_rdata_q    <= sram_rdata;
            i_ready_q    <= 1'b1;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            state_q      <= ST_RESP;
          end
        end
        ST_GRANT_D: begin
          if (sram_ready) begin
            // Only reads refresh the D line; the enable is still high here.
            if (sram_rd_en_q) begin
              d_rdata_q <= sram_rdata;
            end
            d_ready_q    <= 1'b1;
            sram_rd_en_q <= 1'b0;
            sram_wr_en_q <= 1'b0;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_rd_en = sram_rd_en_q;
  assign sram_wr_en = sram_wr_en_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter: a table of single transactions
//   followed by hand-written multi-cycle sequences (arbitration, starvation or
//   round-robin alternation, asynchronous reset mid-transaction).
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0400;
  localparam logic [31:0] D_ADDR = 32'h0000_0900;

  logic        clock;
  logic        rst;
  logic        i_rd_en;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [63:0] i_rdata;
  logic        d_rd_en;
  logic        d_wr_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [63:0] d_rdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ready;
  logic [63:0] sram_rdata;

  int nvec  = 0;
  int nfail = 0;

  sram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LINE_W(64), .STARVE_MAX(4)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .i_rd_en    (i_rd_en),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .d_rd_en    (d_rd_en),
    .d_wr_en    (d_wr_en),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        i_rd;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [63:0] rdata;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_iready;
    logic        exp_dready;
    logic [63:0] exp_irdata;
    logic [63:0] exp_drdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next grant, completes it with one GRANT cycle,
  // checks the ready pulse lands on the granted port, and optionally drops
  // that port's enable during its RESP cycle. Returns 0 for I, 1 for D.
  task automatic serve(input logic drop_i, input logic drop_d, output int port);
    int n;
    n = 0;
    port = -1;
    while (!(sram_rd_en || sram_wr_en) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!(sram_rd_en || sram_wr_en)) begin
      chk("grant_timeout", 64'(n), 64'd0);
      return;
    end
    port = (sram_addr == I_ADDR) ? 0 : 1;
    sram_ready = 1'b1;
    sram_rdata = 64'h5555_AAAA_0000_0001;
    @(negedge clock);
    sram_ready = 1'b0;
    chk("win_ready", (port == 0) ? 64'(i_ready) : 64'(d_ready), 64'd1);
    chk("lose_ready", (port == 0) ? 64'(d_ready) : 64'(i_ready), 64'd0);
    if (port == 0 && drop_i) i_rd_en = 1'b0;
    if (port == 1 && drop_d) begin
      d_rd_en = 1'b0;
      d_wr_en = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    int p;

    vecs[0] = '{i_rd:1'b1, d_rd:1'b0, d_wr:1'b0, addr:32'h400, wdata:32'h0, lat:5,
                rdata:64'hA5A5_0000_1234_5678, exp_rd:1'b1, exp_wr:1'b0,
                exp_iready:1'b1, exp_dready:1'b0,
                exp_irdata:64'hA5A5_0000_1234_5678, exp_drdata:64'h0};
    vecs[1] = '{i_rd:1'b0, d_rd:1'b0, d_wr:1'b1, addr:32'h800, wdata:32'hDEADBEEF, lat:2,
                rdata:64'h1111_1111_1111_1111, exp_rd:1'b0, exp_wr:1'b1,
                exp_iready:1'b0, exp_dready:1'b1,
                exp_irdata:64'hA5A5_0000_1234_5678, exp_drdata:64'h0};
    vecs[2] = '{i_rd:1'b0, d_rd:1'b1, d_wr:1'b0, addr:32'h808, wdata:32'h0, lat:1,
                rdata:64'h0123_4567_89AB_CDEF, exp_rd:1'b1, exp_wr:1'b0,
                exp_iready:1'b0, exp_dready:1'b1,
                exp_irdata:64'hA5A5_0000_1234_5678, exp_drdata:64'h0123_4567_89AB_CDEF};
    vecs[3] = '{i_rd:1'b0, d_rd:1'b1, d_wr:1'b1, addr:32'h810, wdata:32'hCAFEF00D, lat:3,
                rdata:64'hFFFF_FFFF_FFFF_FFFF, exp_rd:1'b0, exp_wr:1'b1,
                exp_iready:1'b0, exp_dready:1'b1,
                exp_irdata:64'hA5A5_0000_1234_5678, exp_drdata:64'h0123_4567_89AB_CDEF};
    vecs[4] = '{i_rd:1'b1, d_rd:1'b0, d_wr:1'b0, addr:32'h404, wdata:32'h0, lat:1,
                rdata:64'h0BAD_F00D_7777_8888, exp_rd:1'b1, exp_wr:1'b0,
                exp_iready:1'b1, exp_dready:1'b0,
                exp_irdata:64'h0BAD_F00D_7777_8888, exp_drdata:64'h0123_4567_89AB_CDEF};

    rst = 1'b1;
    i_rd_en = 1'b0; i_addr = '0;
    d_rd_en = 1'b0; d_wr_en = 1'b0; d_addr = '0; d_wdata = '0;
    sram_ready = 1'b0; sram_rdata = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_en", {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
    chk("rst_ready", {62'd0, i_ready, d_ready}, 64'd0);
    chk("rst_addr", {sram_addr, sram_wdata}, 64'd0);
    chk("rst_irdata", i_rdata, 64'd0);
    chk("rst_drdata", d_rdata, 64'd0);
    rst = 1'b0;
    @(negedge clock);

    // Controller completion while idle must be ignored
    sram_ready = 1'b1;
    sram_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clock);
    sram_ready = 1'b0;
    chk("idle_ready_ignored", {62'd0, i_ready, d_ready}, 64'd0);
    chk("idle_no_en", {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
    chk("idle_irdata", i_rdata, 64'd0);
    @(negedge clock);

    // Table of single transactions
    for (int v = 0; v < 5; v++) begin
      i_rd_en = vecs[v].i_rd;
      d_rd_en = vecs[v].d_rd;
      d_wr_en = vecs[v].d_wr;
      i_addr  = vecs[v].addr;
      d_addr  = vecs[v].addr;
      d_wdata = vecs[v].wdata;
      @(negedge clock);
      chk($sformatf("v%0d_rd_en", v), 64'(sram_rd_en), 64'(vecs[v].exp_rd));
      chk($sformatf("v%0d_wr_en", v), 64'(sram_wr_en), 64'(vecs[v].exp_wr));
      chk($sformatf("v%0d_addr", v), 64'(sram_addr), 64'(vecs[v].addr));
      if (vecs[v].exp_wr) chk($sformatf("v%0d_wdata", v), 64'(sram_wdata), 64'(vecs[v].wdata));
      i_rd_en = 1'b0; d_rd_en = 1'b0; d_wr_en = 1'b0;
      cnt = (sram_rd_en || sram_wr_en) ? 1 : 0;
      for (int k = 2; k <= vecs[v].lat; k++) begin
        @(negedge clock);
        if (sram_rd_en || sram_wr_en) cnt++;
        if (i_ready || d_ready) chk($sformatf("v%0d_early_ready", v), 64'd1, 64'd0);
      end
      chk($sformatf("v%0d_en_cycles", v), 64'(cnt), 64'(vecs[v].lat));
      sram_ready = 1'b1;
      sram_rdata = vecs[v].rdata;
      @(negedge clock);
      sram_ready = 1'b0;
      sram_rdata = 64'h0;
      chk($sformatf("v%0d_en_drop", v), {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
      chk($sformatf("v%0d_i_ready", v), 64'(i_ready), 64'(vecs[v].exp_iready));
      chk($sformatf("v%0d_d_ready", v), 64'(d_ready), 64'(vecs[v].exp_dready));
      chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].exp_irdata);
      chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].exp_drdata);
      @(negedge clock);
      chk($sformatf("v%0d_pulse_end", v), {62'd0, i_ready, d_ready}, 64'd0);
      chk($sformatf("v%0d_idle_en", v), {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: lone D first, then both held -> D, I, D, I
    d_addr = D_ADDR; i_addr = I_ADDR;
    d_rd_en = 1'b1;
    serve(1'b0, 1'b0, p);
    chk("rr_g0_port", 64'(p), 64'd1);
    i_rd_en = 1'b1;
    serve(1'b0, 1'b0, p);
    chk("rr_g1_port", 64'(p), 64'd0);
    serve(1'b0, 1'b0, p);
    chk("rr_g2_port", 64'(p), 64'd1);
    serve(1'b1, 1'b1, p);
    chk("rr_g3_port", 64'(p), 64'd0);
    i_rd_en = 1'b0; d_rd_en = 1'b0;
    @(negedge clock);
`else
    // Simultaneous request: D first, then I on the next IDLE
    d_addr = D_ADDR; i_addr = I_ADDR;
    i_rd_en = 1'b1; d_rd_en = 1'b1;
    serve(1'b1, 1'b1, p);
    chk("both_first_port", 64'(p), 64'd1);
    serve(1'b1, 1'b1, p);
    chk("both_second_port", 64'(p), 64'd0);
    @(negedge clock);
    chk("both_done_en", {62'd0, sram_rd_en, sram_wr_en}, 64'd0);

    // Starvation: I held, D re-requests -> four D grants, then I
    i_rd_en = 1'b1; d_rd_en = 1'b1;
    for (int g = 0; g < 5; g++) begin
      serve(1'b1, 1'b0, p);
      chk($sformatf("starve_g%0d_port", g), 64'(p), (g < 4) ? 64'd1 : 64'd0);
    end
    d_rd_en = 1'b0;
    i_rd_en = 1'b0;
    @(negedge clock);
`endif

    // Asynchronous reset during GRANT_D
    d_wr_en = 1'b1; d_addr = 32'h800; d_wdata = 32'hDEADBEEF;
    @(negedge clock);
    chk("rst6_granted", 64'(sram_wr_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst6_en", {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
    chk("rst6_addr", {sram_addr, sram_wdata}, 64'd0);
    chk("rst6_ready", {62'd0, i_ready, d_ready}, 64'd0);
    chk("rst6_irdata", i_rdata, 64'd0);
    chk("rst6_drdata", d_rdata, 64'd0);
    d_wr_en = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (sram_rd_en || sram_wr_en) cnt++;
    end
    chk("rst6_no_reissue", 64'(cnt), 64'd0);
    i_addr = I_ADDR; i_rd_en = 1'b1;
    serve(1'b1, 1'b1, p);
    chk("rst6_new_req_port", 64'(p), 64'd0);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
